// File: rtl/uart_pkg.sv
// Shared types, constants and baud-divisor helper for the UART receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
  } rx_result_t;

  // Clock cycles per line bit, truncated toward zero.
  function automatic int unsigned clks_per_bit(input int unsigned baud,
                                               input int unsigned clk_ns);
    return 32'd1_000_000_000 / (baud * clk_ns);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, falling-edge detector and bit sampler for the UART receiver.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote; otherwise a single synchronized sample.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst_n,
  input  logic in_serial_bit,
  output logic line,
  output logic fall_c,
  output logic sample_c
);

  logic meta;
  logic prev;
`ifdef UART_RX_MAJORITY_EN
  logic prev2;
`endif

  // Two-flop synchronizer plus a short history; idle-high after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      line  <= 1'b1;
      prev  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      prev2 <= 1'b1;
`endif
    end else begin
      meta  <= in_serial_bit;
      line  <= meta;
      prev  <= line;
`ifdef UART_RX_MAJORITY_EN
      prev2 <= prev;
`endif
    end
  end

  assign fall_c = prev & ~line;

  // Both variants are centred on the previous cycle so decision timing is identical.
`ifdef UART_RX_MAJORITY_EN
  assign sample_c = (line & prev) | (line & prev2) | (prev & prev2);
`else
  assign sample_c = prev;
`endif

endmodule

// File: rtl/uart_receiver.sv
// 7E1 UART receiver: start, 7 data bits LSB first, even parity, one stop bit.
// Optional 2-of-3 majority sampling via UART_RX_MAJORITY_EN (see uart_rx_sampler).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned CLK_PERIOD_NS = 50
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_serial_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CPB   = clks_per_bit(BAUD_RATE, CLK_PERIOD_NS);
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB + 1);
  localparam int unsigned BC_W  = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_PT = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_PT  = CNT_W'(CPB - 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_BITS - 1);

  logic sync_line;
  logic fall_c;
  logic sample_c;

  uart_rx_sampler u_sampler (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_serial_bit (in_serial_bit),
    .line          (sync_line),
    .fall_c        (fall_c),
    .sample_c      (sample_c)
  );

  rx_state_e            state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  rx_result_t           res_q, res_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Bit-timing counter restarts at every sample point; frame is resolved at the stop sample.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_W'(1);
    bit_cnt_d = bit_cnt;
    shift_d   = shift_q;
    par_d     = par_q;
    res_d     = res_q;
    valid_d   = 1'b0;

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (fall_c) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (cnt == HALF_PT) begin
          cnt_d   = '0;
          state_d = sample_c ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_PT) begin
          cnt_d   = '0;
          shift_d = {sample_c, shift_q[DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt + BC_W'(1);
          end
        end
      end
      PARITY: begin
        if (cnt == BIT_PT) begin
          cnt_d   = '0;
          par_d   = sample_c;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_PT) begin
          cnt_d            = '0;
          res_d.data       = shift_q;
          res_d.parity_err = (^shift_q) ^ par_q;
          res_d.frame_err  = ~sample_c;
          valid_d          = 1'b1;
          state_d          = sample_c ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (sync_line) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign rx_data    = res_q.data;
  assign parity_err = res_q.parity_err;
  assign frame_err  = res_q.frame_err;
  assign rx_valid   = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 9600 baud with a 50-cycle bit time.
module tb_uart_receiver;

  localparam int unsigned CPB = 50;  // 1e9 / (9600 * 2083) truncated

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       line = 1'b1;
  logic [6:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_receiver #(
    .BAUD_RATE     (9600),
    .CLK_PERIOD_NS (2083)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_serial_bit (line),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         valid_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mk_frame(input logic [6:0] d, input logic bad_par,
                                          input logic stop);
    return {stop, (^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [6:0] d, input logic bad_par, input logic stop);
    logic [9:0] f;
    f = mk_frame(d, bad_par, stop);
    exp_q.push_back({d, bad_par, ~stop});
    for (int i = 0; i < 10; i++) begin
      line = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: every rx_valid must match the oldest outstanding frame.
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    if (rst_n && rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      check("valid_pulse", 32'(prev_valid), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(rx_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e[8:2]));
        check("parity_err", 32'(parity_err), 32'(e[1]));
        check("frame_err", 32'(frame_err), 32'(e[0]));
      end
    end
    prev_valid <= rx_valid;
  end

  initial begin
    logic [9:0] f;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(2 * CPB);

    send_frame(7'h55, 1'b0, 1'b1);
    check("drain_55", exp_q.size(), 0);
    idle(CPB);

    send_frame(7'h23, 1'b1, 1'b1);
    check("drain_23", exp_q.size(), 0);
    idle(CPB);

    // Stop bit low, line then held low for three bit times.
    send_frame(7'h7F, 1'b0, 1'b0);
    line = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("busy_wait_idle", 32'(busy), 1);
    check("drain_7f", exp_q.size(), 0);
    line = 1'b1;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    check("busy_release", 32'(busy), 0);
    idle(CPB);

    // Short low glitch on an idle line must be rejected.
    line = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_busy", 32'(busy), 1);
    line = 1'b1;
    for (int i = 0; i < (CPB / 2 + 10 - 12) && busy; i++) @(negedge clk);
    check("glitch_busy_drop", 32'(busy), 0);
    check("hold_rx_data", 32'(rx_data), 32'h7F);
    check("hold_frame_err", 32'(frame_err), 1);
    idle(2 * CPB);

    // Reset in the middle of data bit 3 of 0x41.
    f = mk_frame(7'h41, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      line = f[i];
      repeat (CPB) @(negedge clk);
    end
    line = f[4];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rx_data", 32'(rx_data), 0);
    check("midrst_frame_err", 32'(frame_err), 0);
    line = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * CPB);
    check("midrst_no_valid", exp_q.size(), 0);
    send_frame(7'h12, 1'b0, 1'b1);
    check("drain_12", exp_q.size(), 0);
    idle(CPB);

    // Back-to-back frames with no idle gap.
    send_frame(7'h01, 1'b0, 1'b1);
    send_frame(7'h7E, 1'b0, 1'b1);
    check("drain_b2b", exp_q.size(), 0);
    idle(CPB);

    for (int k = 0; k < 4; k++) begin
      send_frame(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'b1);
      idle(CPB / 2);
    end
    check("drain_rand", exp_q.size(), 0);

    idle(2 * CPB);
    check("valid_count", valid_cnt, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
